// File: rtl/ex_div_unit.sv
// ex_div_unit: radix-2 restoring DIV/DIVU, one quotient bit per cycle; ready pulses WIDTH+1 cycles after start (2 for divide-by-zero).
// Holds stallreq while busy, annul cancels from any state; DIV_EARLY_OUT_EN finishes in 1 cycle when |divisor| > |dividend|.
module ex_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic             annul,
  input  logic [WIDTH-1:0] opdata1,
  input  logic [WIDTH-1:0] opdata2,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             ready,
  output logic             stallreq
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_RUN, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dvd, r_rem, r_dvs, r_quot, r_remd;
  logic             r_neg_q, r_neg_r;

  logic             w_go, w_op1_neg, w_op2_neg, w_early, w_last;
  logic [WIDTH-1:0] w_abs1, w_abs2, w_rem_nxt, w_quo_nxt;
  logic [WIDTH:0]   w_shift, w_diff;

  assign w_go      = start && !annul;
  assign w_op1_neg = signed_div && opdata1[WIDTH-1];
  assign w_op2_neg = signed_div && opdata2[WIDTH-1];
  assign w_abs1    = w_op1_neg ? -opdata1 : opdata1;
  assign w_abs2    = w_op2_neg ? -opdata2 : opdata2;
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

`ifdef DIV_EARLY_OUT_EN
  assign w_early = (w_abs2 > w_abs1);
`else
  assign w_early = 1'b0;
`endif

  // Partial remainder stays below the divisor, so one extra bit holds the shifted value.
  assign w_shift   = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_dvs};
  assign w_rem_nxt = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_quo_nxt = {r_dvd[WIDTH-2:0], ~w_diff[WIDTH]};

  assign quotient  = r_quot;
  assign remainder = r_remd;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    stallreq = 1'b0;
    ready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          stallreq = 1'b1;
          if (opdata2 == '0)  w_next = S_DIVZERO;
          else if (w_early)   w_next = S_DONE;
          else                w_next = S_RUN;
        end
      end
      S_DIVZERO: begin
        stallreq = 1'b1;
        w_next   = S_DONE;
      end
      S_RUN: begin
        stallreq = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        ready  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (annul) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_quot  <= '0;
      r_remd  <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (!annul) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dvd   <= w_abs1;
            r_dvs   <= w_abs2;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_neg_q <= w_op1_neg ^ w_op2_neg;
            r_neg_r <= w_op1_neg;
            if ((opdata2 != '0) && w_early) begin
              r_quot <= '0;
              r_remd <= opdata1;
            end
          end
        end
        S_DIVZERO: begin
          r_quot <= '0;
          r_remd <= '0;
        end
        S_RUN: begin
          r_rem <= w_rem_nxt;
          r_dvd <= w_quo_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_quot <= r_neg_q ? -w_quo_nxt : w_quo_nxt;
            r_remd <= r_neg_r ? -w_rem_nxt : w_rem_nxt;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_div_unit.sv
// Testbench for ex_div_unit: vector table run back-to-back through a result scoreboard,
// plus annul, mid-run reset and back-to-back spacing sequences.
module tb_ex_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, signed_div, annul;
  logic [W-1:0] opdata1, opdata2, quotient, remainder;
  logic         ready, stallreq;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic        sd;
    logic [31:0] a, b, q, r;
  } vec_t;

  typedef struct {
    logic [31:0] q, r;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   ready_at[$];
  vec_t vt[14];

  ex_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div), .annul(annul),
    .opdata1(opdata1), .opdata2(opdata2), .quotient(quotient), .remainder(remainder),
    .ready(ready), .stallreq(stallreq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic sd, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    ma = (sd && a[31]) ? (32'd0 - a) : a;
    mb = (sd && b[31]) ? (32'd0 - b) : b;
    if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
    if (mb > ma) return 1;
`endif
    if (ma == mb) return 33;
    return 33;
  endfunction

  task automatic set_v(input int i, input logic sd, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] q, input logic [31:0] r);
    vt[i].sd = sd; vt[i].a = a; vt[i].b = b; vt[i].q = q; vt[i].r = r;
  endtask

  // Called just after a posedge; returns just after the posedge that ends the ready cycle.
  task automatic run_op(input logic sd, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic [31:0] r);
    exp_t e;
    int   lat, stalls;
    bit   seen;
    e.q = q; e.r = r; e.lat = exp_lat(sd, a, b);
    sb.push_back(e);
    start = 1'b1; signed_div = sd; opdata1 = a; opdata2 = b; annul = 1'b0;
    lat = 0; stalls = 0; seen = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      if (ready) seen = 1'b1;
      else begin
        if (stallreq) stalls++;
        @(posedge clk); #1;
        lat++;
      end
    end
    e = sb.pop_front();
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL ready_timeout %h/%h: got no ready in %0d cycles expected ready at %0d", a, b, lat, e.lat);
    end else begin
      ready_at.push_back(cyc);
      chk("quotient", quotient, e.q);
      chk("remainder", remainder, e.r);
      chk("latency", lat, e.lat);
      chk("stall_cycles", stalls, e.lat);
      chk("stallreq_in_done", {31'd0, stallreq}, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int nr, spur;
    rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0; opdata1 = '0; opdata2 = '0;

    set_v(0,  1'b0, 32'd100,        32'd7,          32'd14,         32'd2);
    set_v(1,  1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF);
    set_v(2,  1'b0, 32'h00001234,   32'd0,          32'd0,          32'd0);
    set_v(3,  1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0);
    set_v(4,  1'b0, 32'd9,          32'd3,          32'd3,          32'd0);
    set_v(5,  1'b0, 32'd10,         32'd4,          32'd2,          32'd2);
    set_v(6,  1'b0, 32'd3,          32'd8,          32'd0,          32'd3);
    set_v(7,  1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF);
    set_v(8,  1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0);
    set_v(9,  1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0);
    set_v(10, 1'b1, 32'h80000000,   32'd2,          32'hC0000000,   32'd0);
    set_v(11, 1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000);
    set_v(12, 1'b1, 32'hFFFFFFFB,   32'd0,          32'd0,          32'd0);
    set_v(13, 1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_quotient", quotient, 32'd0);
    chk("reset_remainder", remainder, 32'd0);
    chk("reset_ready", {31'd0, ready}, 32'd0);
    chk("reset_stallreq", {31'd0, stallreq}, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) run_op(vt[i].sd, vt[i].a, vt[i].b, vt[i].q, vt[i].r);
    start = 1'b0;
    if (ready_at.size() >= 6) chk("b2b_spacing_table", ready_at[5] - ready_at[4], 32'd34);
    else begin n_tests++; n_fail++; $display("FAIL b2b_spacing_table: got %0d ready pulses expected 6+", ready_at.size()); end

    // Annul in the middle of a run: no ready, results of the previous divide kept.
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3;
    repeat (10) @(posedge clk);
    #1 annul = 1'b1; start = 1'b0;
    @(posedge clk);
    #1 annul = 1'b0;
    @(negedge clk);
    chk("annul_stallreq", {31'd0, stallreq}, 32'd0);
    chk("annul_quotient_kept", quotient, 32'hFFFFFFFD);
    chk("annul_remainder_kept", remainder, 32'd1);
    spur = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready) spur++;
    end
    chk("annul_no_ready", spur, 32'd0);

    @(posedge clk); #1;
    nr = ready_at.size();
    run_op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0);
    run_op(1'b0, 32'd10, 32'd4, 32'd2, 32'd2);
    start = 1'b0;
    if (ready_at.size() == nr + 2) chk("b2b_spacing", ready_at[nr+1] - ready_at[nr], 32'd34);
    else begin n_tests++; n_fail++; $display("FAIL b2b_spacing: got %0d pulses expected 2", ready_at.size() - nr); end

    // Synchronous reset in the middle of a run clears everything.
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("midrst_quotient", quotient, 32'd0);
    chk("midrst_remainder", remainder, 32'd0);
    chk("midrst_ready", {31'd0, ready}, 32'd0);
    chk("midrst_stallreq", {31'd0, stallreq}, 32'd0);

    @(posedge clk); #1;
    run_op(1'b0, 32'd3, 32'd8, 32'd0, 32'd3);
    run_op(1'b1, 32'hFFFFFFFD, 32'd8, 32'd0, 32'hFFFFFFFD);
    start = 1'b0;
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ex_div_unit.md
Name: ex_div_unit

Overview:
- Iterative radix-2 32-bit divider in the EX stage; serves DIV/DIVU.
- Requester side of the pipeline stall protocol: drives stallreq to the stall controller while busy.
- The controller answers with stall=6'b001111, freezing PC/IF/ID/EX, so operands and start stay stable for the whole operation.
- Results go to HI (remainder) and LO (quotient) through the EX/MEM path.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  divide request from EX decode; held while stallreq=1
- signed_div  in  1  1=DIV (two's complement), 0=DIVU
- annul  in  1  flush/exception cancel; aborts operation
- opdata1  in  WIDTH  dividend
- opdata2  in  WIDTH  divisor
- quotient  out  WIDTH  registered quotient (to LO)
- remainder  out  WIDTH  registered remainder (to HI)
- ready  out  1  one-cycle pulse, result valid
- stallreq  out  1  stall request to controller (EX-level stall)

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; quotient=0, remainder=0, ready=0, counter=0, working registers=0. Reset mid-operation abandons it immediately; stallreq=0 from the next cycle.
- States: IDLE, DIVZERO, RUN, DONE.
- stallreq is combinational: 1 when (state==IDLE && start && !annul) or state in {DIVZERO, RUN}; 0 in DONE and otherwise.
- IDLE:
  - start=1, annul=0, opdata2==0 -> DIVZERO.
  - start=1, annul=0, opdata2!=0 -> latch magnitudes (negate negative operands when signed_div=1), latch sign flags, counter=0 -> RUN.
  - Else stay in IDLE.
- DIVZERO: one cycle -> DONE with quotient=0, remainder=0.
- RUN: one restoring step per cycle.
  - Shift {partial_rem, dividend} left by 1; trial subtract the divisor magnitude.
  - Non-negative difference: keep it, shift in quotient bit 1; else shift in 0.
  - counter increments; after the WIDTH-th step (counter==WIDTH-1) -> DONE.
- On entry to DONE (registered):
  - quotient = raw quotient, negated if signed and sign(op1)!=sign(op2).
  - remainder = raw remainder, negated if signed and op1 negative.
- DONE: ready=1 for exactly one cycle, stallreq=0; unconditionally -> IDLE.
- Outputs hold their value until the next DONE or reset.
- Latency: start first seen at cycle 0 -> ready at cycle WIDTH+1 (33). stallreq high in cycles 0..32.
- Back-to-back divides: pipeline advances during the DONE cycle; the new start is seen in IDLE the next cycle. No start is lost and none is double-counted.
- annul=1 in any state -> IDLE next cycle, ready stays 0, quotient/remainder unchanged. annul has priority over start.
- Overflow 0x80000000 / 0xFFFFFFFF signed -> quotient 0x80000000, remainder 0 (natural wrap, no trap).
- start dropping mid-RUN without annul is illegal. The unit ignores it and completes.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined: in IDLE, if the divisor magnitude exceeds the dividend magnitude (opdata2!=0), go directly to DONE with quotient=0 and remainder=opdata1 (original signed value). ready at cycle 1; stallreq high only in cycle 0.
- Undefined: such cases take the full WIDTH iterations with identical final results.

Test Plan:
- DIVU 100/7 -> stallreq high 33 cycles, ready pulse at cycle 33, quotient=14, remainder=2.
- DIV -7/2 (0xFFFFFFF9 / 2) -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1).
- Divisor zero, opdata1=0x1234 -> DIVZERO path, ready at cycle 2, quotient=0, remainder=0.
- DIV 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
- annul=1 at cycle 10 of RUN -> IDLE next cycle, stallreq=0, no ready pulse, previous results retained. Then back-to-back DIVU 9/3 and 10/4 -> two ready pulses 34 cycles apart, results 3/0 then 2/2.
- rst=1 at cycle 5 of RUN -> all outputs 0 next cycle. With DIV_EARLY_OUT_EN, DIVU 3/8 -> ready at cycle 1, quotient=0, remainder=3.
